// File: rtl/vec_mag_pkg.sv
// Shared types and width helpers for the sequential vector-magnitude unit.
// Optional build macro: VEC_MAG_ROUND_EN (round-to-nearest result).
package vec_mag_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SQ   = 2'd1;
  localparam logic [1:0] ST_RT   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SQ   = ST_SQ,
    RT   = ST_RT,
    DONE = ST_DONE
  } state_e;

  // Result width: sqrt(2)*(2^W-1) always fits in W+1 bits.
  function automatic int res_w(input int w);
    return w + 1;
  endfunction

  // Sum-of-squares width: 2*(2^W-1)^2 fits in 2W+1 bits.
  function automatic int sum_w(input int w);
    return 2 * w + 1;
  endfunction

  // Shared counter must reach W (last root iteration).
  function automatic int cnt_w(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/vec_mag_seq_isqrt_step.sv
// One restoring square-root iteration: brings down the next radicand bit pair
// and decides one result bit. Purely combinational, reused every root cycle.
module isqrt_step #(
  parameter int RW = 9              // result width; remainder is RW+1 bits
) (
  input  logic [RW:0]   rem_i,
  input  logic [RW-1:0] res_i,
  input  logic [1:0]    pair_i,
  output logic [RW:0]   rem_o,
  output logic [RW-1:0] res_o
);

  logic [RW+2:0] rem_sh;
  logic [RW+2:0] trial;
  logic [RW+2:0] diff;
  logic          ge;

  // Trial subtract of (4*res + 1); the remainder never exceeds 2*res so the
  // truncated outputs always hold the full value.
  always_comb begin
    rem_sh = {rem_i, pair_i};
    trial  = {1'b0, res_i, 2'b01};
    diff   = rem_sh - trial;
    ge     = (rem_sh >= trial);
    rem_o  = ge ? diff[RW:0] : rem_sh[RW:0];
    res_o  = {res_i[RW-2:0], ge};
  end

endmodule

// File: rtl/vec_mag_seq.sv
// Sequential Euclidean magnitude: shift-add squaring then digit-by-digit root.
// Optional build macro: VEC_MAG_ROUND_EN (round to nearest instead of floor).
module vec_mag_seq
  import vec_mag_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W:0]     out_mag,
  output logic           busy
);

  localparam int RES_W = res_w(W);
  localparam int SUM_W = sum_w(W);
  localparam int CNT_W = cnt_w(W);
  localparam int RAD_W = SUM_W + 1;   // padded to an even number of bits
  localparam int REM_W = W + 2;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       x_q, x_d, y_q, y_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [RAD_W-1:0]   rad_q, rad_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [RES_W-1:0]   mag_q, mag_d;

  logic [W-1:0]       x_sh, y_sh;
  logic [SUM_W-1:0]   x_term, y_term, acc_sum;
  logic [REM_W-1:0]   step_rem;
  logic [RES_W-1:0]   step_res;

  isqrt_step #(.RW(RES_W)) u_step (
    .rem_i  (rem_q),
    .res_i  (res_q),
    .pair_i (rad_q[RAD_W-1 -: 2]),
    .rem_o  (step_rem),
    .res_o  (step_res)
  );

  // Partial products of the current bit of each operand.
  always_comb begin
    x_sh    = x_q >> cnt_q;
    y_sh    = y_q >> cnt_q;
    x_term  = x_sh[0] ? (SUM_W'(x_q) << cnt_q) : '0;
    y_term  = y_sh[0] ? (SUM_W'(y_q) << cnt_q) : '0;
    acc_sum = acc_q + x_term + y_term;
  end

  // Next-state and datapath update for IDLE -> SQ -> RT -> DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    res_d   = res_q;
    mag_d   = mag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          y_d     = in_y;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SQ;
        end
      end
      SQ: begin
        acc_d = acc_sum;
        if (cnt_q == CNT_W'(W - 1)) begin
          rad_d   = {1'b0, acc_sum};
          rem_d   = '0;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RT: begin
        rad_d = rad_q << 2;
        rem_d = step_rem;
        res_d = step_res;
        if (cnt_q == CNT_W'(W)) begin
`ifdef VEC_MAG_ROUND_EN
          mag_d = step_res + RES_W'(step_rem > {1'b0, step_res});
`else
          mag_d = step_res;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over the clock enable, ena low freezes all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      mag_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      mag_q   <= mag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_mag   = mag_q;

endmodule

// File: tb/tb_vec_mag_seq.sv
// Directed and reference-model checks of vec_mag_seq at W=8 and W=16.
module tb_vec_mag_seq;

`ifdef VEC_MAG_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ena8 = 1'b1, in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0]  in_x8 = '0, in_y8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [8:0]  out_mag8;

  logic        ena16 = 1'b1, in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] in_x16 = '0, in_y16 = '0;
  logic        in_ready16, out_valid16, busy16;
  logic [16:0] out_mag16;

  int n_checks = 0;
  int n_errors = 0;

  vec_mag_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .ena(ena8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_x(in_x8), .in_y(in_y8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_mag(out_mag8), .busy(busy8)
  );

  vec_mag_seq #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .ena(ena16), .in_valid(in_valid16), .in_ready(in_ready16),
    .in_x(in_x16), .in_y(in_y16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_mag(out_mag16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: floor sqrt by binary search, then optional round-to-nearest.
  function automatic longint ref_mag(input longint x, input longint y);
    longint s, lo, hi, mid;
    s  = x * x + y * y;
    lo = 0;
    hi = 64'd1 << 18;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= s) lo = mid;
      else hi = mid;
    end
    if (ROUND && (s - lo * lo) > lo) lo = lo + 1;
    return lo;
  endfunction

  // Present one pair on the W=8 unit; returns after the acceptance edge.
  task automatic start8(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    in_x8 = x; in_y8 = y; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    in_x8 = ~x; in_y8 = ~y;
  endtask

  // Count edges until out_valid; optionally drop ena for 5 edges after edge gate_at.
  task automatic wait8(output int n, output bit ready_low, input int gate_at);
    n = 0;
    ready_low = 1'b1;
    while (!out_valid8 && n < 100) begin
      if (gate_at >= 0 && n == gate_at) ena8 = 1'b0;
      if (gate_at >= 0 && n == gate_at + 5) ena8 = 1'b1;
      @(posedge clk); #1;
      n++;
      if (in_ready8) ready_low = 1'b0;
    end
    ena8 = 1'b1;
  endtask

  task automatic release8(input string tag);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check({tag, "_ready_after"}, in_ready8, 1);
    check({tag, "_valid_after"}, out_valid8, 0);
  endtask

  task automatic do8(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input int exp_mag, input int exp_lat, input int gate_at);
    int  n;
    bit  low;
    start8(x, y);
    wait8(n, low, gate_at);
    $display("w8 %s: x=%0d y=%0d mag=%0d lat=%0d", tag, x, y, out_mag8, n);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_mag"}, out_mag8, exp_mag);
    check({tag, "_ready_low"}, low, 1);
    release8(tag);
  endtask

  task automatic do16(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input int exp_mag);
    int n;
    @(negedge clk);
    in_x16 = x; in_y16 = y; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    $display("w16 %s: x=%0d y=%0d mag=%0d lat=%0d", tag, x, y, out_mag16, n);
    check({tag, "_lat"}, n, 33);
    check({tag, "_mag"}, out_mag16, exp_mag);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    check({tag, "_ready_after"}, in_ready16, 1);
  endtask

  initial begin
    int  n;
    bit  low;
    bit  hold_ok;
    logic [8:0] held;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", in_ready8, 1);
    check("rst_out_valid", out_valid8, 0);
    check("rst_out_mag", out_mag8, 0);
    check("rst_busy", busy8, 0);

    // Basic vectors; in_ready must stay low through edges 1..17.
    do8("p3_4", 8'd3, 8'd4, 5, 17, -1);
    do8("p0_0", 8'd0, 8'd0, 0, 17, -1);
    do8("p255_255", 8'd255, 8'd255, ROUND ? 361 : 360, 17, -1);
    do8("p2_3", 8'd2, 8'd3, ROUND ? 4 : 3, 17, -1);
    do8("p1_1", 8'd1, 8'd1, 1, 17, -1);

    // Backpressure: hold the result 10 cycles while new requests are offered.
    start8(8'd9, 8'd12);
    wait8(n, low, -1);
    check("bp_lat", n, 17);
    check("bp_mag", out_mag8, 15);
    held = out_mag8;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid8 = 1'b1;
      in_x8 = 8'($urandom);
      in_y8 = 8'($urandom);
      @(posedge clk); #1;
      if (!out_valid8 || out_mag8 !== held) hold_ok = 1'b0;
    end
    in_valid8 = 1'b0;
    $display("w8 bp: held mag=%0d for 10 cycles", held);
    check("bp_hold", hold_ok, 1);
    release8("bp");
    @(posedge clk); #1;
    check("bp_no_capture", busy8, 0);

    // Reset during the root phase aborts the operation.
    start8(8'd20, 8'd21);
    repeat (12) @(posedge clk);
    #1 check("rt_busy", busy8, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    $display("w8 rst_mid: in_ready=%0d out_valid=%0d mag=%0d", in_ready8, out_valid8, out_mag8);
    check("rst_mid_ready", in_ready8, 1);
    check("rst_mid_valid", out_valid8, 0);
    check("rst_mid_mag", out_mag8, 0);
    check("rst_mid_busy", busy8, 0);
    do8("p6_8", 8'd6, 8'd8, 10, 17, -1);

    // Clock-enable gap of 5 cycles during squaring stretches latency by 5.
    do8("ena_gap", 8'd5, 8'd12, 13, 22, 2);

    // Wide configuration: corners plus random pairs against the reference.
    do16("m65535_0", 16'd65535, 16'd0, 65535);
    do16("m65535_65535", 16'd65535, 16'd65535, 92680);
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] rx, ry;
      rx = 16'($urandom);
      ry = 16'($urandom);
      do16("rand", rx, ry, int'(ref_mag(longint'(rx), longint'(ry))));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
